// File: rtl/csr_access_unit.sv
// csr_access_unit: initiator side of the CSR interface.
// Runs Zicsr read-modify-write sequences (CSRRW/RS/RC and the immediate forms) against
// a CSR file with combinational read data, and returns the old value or an illegal flag.
module csr_access_unit #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ADDR_W   = 12,
  parameter bit          RO_CHECK = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_operand,
  input  logic              req_src_zero,
  output logic [ADDR_W-1:0] csr_addr,
  input  logic [XLEN-1:0]   csr_rdata,
  output logic [XLEN-1:0]   csr_wdata,
  output logic              csr_we,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_illegal
);

  localparam logic [1:0] OP_RSV = 2'b00;
  localparam logic [1:0] OP_RW  = 2'b01;
  localparam logic [1:0] OP_RS  = 2'b10;
  localparam logic [1:0] OP_RC  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Latched request fields (the address lives in csr_addr_q)
  logic [1:0]        op_q, op_d;
  logic [XLEN-1:0]   operand_q, operand_d;
  logic              src_zero_q, src_zero_d;

  // Registered outputs
  logic              req_ready_q, req_ready_d;
  logic [ADDR_W-1:0] csr_addr_q, csr_addr_d;
  logic [XLEN-1:0]   csr_wdata_q, csr_wdata_d;
  logic              csr_we_q, csr_we_d;
  logic              resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
  logic              resp_illegal_q, resp_illegal_d;

  logic              accept_c;
  logic              ro_addr_c;
  logic              do_write_c;
  logic              illegal_c;
  logic [XLEN-1:0]   new_c;

  assign req_ready    = req_ready_q;
  assign csr_addr     = csr_addr_q;
  assign csr_wdata    = csr_wdata_q;
  assign csr_we       = csr_we_q;
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_illegal = resp_illegal_q;

  // Request acceptance and read-phase decisions on the latched request
  always_comb begin
    accept_c   = (state_q == S_IDLE) && req_valid && !flush;
    ro_addr_c  = (csr_addr_q[ADDR_W-1 -: 2] == 2'b11);
    do_write_c = (op_q == OP_RW) || !src_zero_q;
    illegal_c  = (op_q == OP_RSV) || (RO_CHECK && do_write_c && ro_addr_c);
    case (op_q)
      OP_RW:   new_c = operand_q;
      OP_RS:   new_c = csr_rdata | operand_q;
      OP_RC:   new_c = csr_rdata & ~operand_q;
      default: new_c = csr_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush in WRITE is ignored for the commit but suppresses the response
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) state_d = S_READ;
      end
      S_READ: begin
        if (flush)           state_d = S_IDLE;
        else if (illegal_c)  state_d = S_RESP;
        else if (do_write_c) state_d = S_WRITE;
        else                 state_d = S_RESP;
      end
      S_WRITE: begin
        state_d = flush ? S_IDLE : S_RESP;
      end
      S_RESP: begin
        if (flush || resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / field next values, registered so each output reflects the state being entered
  always_comb begin
    req_ready_d    = (state_d == S_IDLE);
    csr_we_d       = (state_d == S_WRITE);
    resp_valid_d   = (state_d == S_RESP);
    csr_addr_d     = csr_addr_q;
    csr_wdata_d    = csr_wdata_q;
    resp_rdata_d   = resp_rdata_q;
    resp_illegal_d = resp_illegal_q;
    op_d           = op_q;
    operand_d      = operand_q;
    src_zero_d     = src_zero_q;
    if (accept_c) begin
      op_d       = req_op;
      csr_addr_d = req_addr;
      operand_d  = req_operand;
      src_zero_d = req_src_zero;
    end
    if ((state_q == S_READ) && (state_d != S_IDLE)) begin
      resp_rdata_d   = illegal_c ? '0 : csr_rdata;
      resp_illegal_d = illegal_c;
      if (state_d == S_WRITE) csr_wdata_d = new_c;
    end
  end

  // Datapath and output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q           <= 2'b00;
      operand_q      <= '0;
      src_zero_q     <= 1'b0;
      req_ready_q    <= 1'b1;
      csr_addr_q     <= '0;
      csr_wdata_q    <= '0;
      csr_we_q       <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= '0;
      resp_illegal_q <= 1'b0;
    end else begin
      op_q           <= op_d;
      operand_q      <= operand_d;
      src_zero_q     <= src_zero_d;
      req_ready_q    <= req_ready_d;
      csr_addr_q     <= csr_addr_d;
      csr_wdata_q    <= csr_wdata_d;
      csr_we_q       <= csr_we_d;
      resp_valid_q   <= resp_valid_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_illegal_q <= resp_illegal_d;
    end
  end

endmodule
